ram_arbiter: RTL

- Shares the single-port data/instruction RAM between two requesters: port D (load/store unit) and port I (instruction fetch).
- Issues at most one RAM access per cycle.
- Tracks which port owns the one-cycle-latency read response and routes the returned data back to that port only.
- Fixed priority goes to port D. A starvation counter forces a grant to port I after a bounded number of denied cycles.

---
 rtl/ram_arbiter_pkg.sv | 20 ++
 rtl/ram_arbiter_starve_cnt.sv | 41 ++++
 rtl/ram_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the RAM arbiter: access size codes and the
// encodings of the registered read-response owner.
package ram_arbiter_pkg;

    // Access size codes carried on d_size_i / mem_size_o
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b011;
    localparam logic [2:0] SZ_HU = 3'b100;

    // Which port owns the read data returning from the RAM this cycle
    localparam logic [1:0] OWN_IDLE = 2'd0;
    localparam logic [1:0] OWN_D    = 2'd1;
    localparam logic [1:0] OWN_I    = 2'd2;

    // Starvation counter width; holds STARVE_MAX up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/ram_arbiter_starve_cnt.sv
// Starvation tracker for the fetch port: counts consecutive cycles in
// which the fetch port requested but was denied, saturating at
// STARVE_MAX, and raises force_i once the limit is reached so the
// arbiter hands the next conflicting cycle to the fetch port.
module arb_starve_cnt
    import ram_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_gnt,
    output logic force_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Count denied cycles; any grant or idle cycle restarts the count
    always_comb begin
        cnt_next = '0;
        if (i_req && !i_gnt) begin
            cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
        end
    end

    // Counter register, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign force_i = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the load/store port (D) and the
// instruction-fetch port (I). One access per cycle, D has priority
// unless the fetch port has been starved for STARVE_MAX cycles. Read
// data returns one cycle after the grant and is steered to the port
// that issued the read.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    // Load/store port
    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    input  logic              d_we_i,
    input  logic [2:0]        d_size_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    // Instruction-fetch port
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [31:0]       i_rdata_o,
    // RAM side
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [2:0]        mem_size_o,
    input  logic [31:0]       mem_data_i
);

    localparam int NPORT = 2;
    // Owner code per response slot: slot 0 is port D, slot 1 is port I
    localparam logic [1:0] PORT_OWN [NPORT] = '{OWN_D, OWN_I};

    logic             force_i;
    logic [1:0]       owner_reg;
    logic [1:0]       owner_next;
    logic [NPORT-1:0] resp_valid;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req_i),
        .i_gnt   (i_gnt_o),
        .force_i (force_i)
    );

    // Grant decision: D first, I when alone or when starved; nothing in reset
    always_comb begin
        d_gnt_o = 1'b0;
        i_gnt_o = 1'b0;
        if (!rst) begin
            if (d_req_i && i_req_i) begin
                if (force_i) begin
                    i_gnt_o = 1'b1;
                end else begin
                    d_gnt_o = 1'b1;
                end
            end else if (d_req_i) begin
                d_gnt_o = 1'b1;
            end else if (i_req_i) begin
                i_gnt_o = 1'b1;
            end
        end
    end

    // RAM request mux; idle cycles drive all-zero so the bus is quiet
    always_comb begin
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_we_o   = 1'b0;
        mem_re_o   = 1'b0;
        mem_size_o = '0;
        if (d_gnt_o) begin
            mem_addr_o = d_addr_i;
            mem_data_o = d_wdata_i;
            mem_we_o   = d_we_i;
            mem_re_o   = !d_we_i;
            mem_size_o = d_size_i;
        end else if (i_gnt_o) begin
            mem_addr_o = i_addr_i;
            mem_re_o   = 1'b1;
            mem_size_o = SZ_W;
        end
    end

    // Next response owner: only a read grant produces returning data
    always_comb begin
        owner_next = OWN_IDLE;
        if (d_gnt_o && !d_we_i) begin
            owner_next = OWN_D;
        end else if (i_gnt_o) begin
            owner_next = OWN_I;
        end
    end

    // Response-owner register; reset drops any in-flight response
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg <= OWN_IDLE;
        end else begin
            owner_reg <= owner_next;
        end
    end

    // Per-port response valid; gated by rst so a read granted just before
    // reset never shows up during the reset cycle
    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_resp
            assign resp_valid[gi] = (owner_reg == PORT_OWN[gi]) && !rst;
        end
    endgenerate

    assign d_rvalid_o = resp_valid[0];
    assign i_rvalid_o = resp_valid[1];
    assign d_rdata_o  = resp_valid[0] ? mem_data_i : 32'h0;
    assign i_rdata_o  = resp_valid[1] ? mem_data_i : 32'h0;

endmodule
